// File: rtl/stack_unit.sv
// stack_unit: LIFO operand stack for the stack-machine controller.
// Commands are push, pop, tos and push+pop (replace-top). Read data is
// registered, so it appears on dout one cycle after the command, qualified
// by a single-cycle dout_valid pulse. ovf and unf stay set until clr_err.
module stack_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             tos,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_err,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             ovf,
    output logic             unf
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] top_idx;
    logic [AW-1:0] wr_idx;
    logic          wr_en;
    logic          rd_en;
    logic          dout_zero;
    logic          cnt_inc;
    logic          cnt_dec;
    logic          ovf_set;
    logic          unf_set;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // count-1 only matters when the stack is non-empty, so truncation is safe.
    assign top_idx = AW'(count - CW'(1));

    // Decode the command into storage, pointer, read-out and error actions.
    always_comb begin
        wr_en     = 1'b0;
        wr_idx    = AW'(count);
        rd_en     = 1'b0;
        dout_zero = 1'b0;
        cnt_inc   = 1'b0;
        cnt_dec   = 1'b0;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        case ({push, pop})
            2'b10: begin
                if (!full) begin
                    wr_en   = 1'b1;
                    cnt_inc = 1'b1;
                end else begin
                    ovf_set = 1'b1;
                end
            end
            2'b01: begin
                if (!empty) begin
                    rd_en   = 1'b1;
                    cnt_dec = 1'b1;
                end else begin
                    dout_zero = 1'b1;
                    unf_set   = 1'b1;
                end
            end
            2'b11: begin
                if (!empty) begin
                    // Replace-top: old top goes out, din takes its slot.
                    rd_en  = 1'b1;
                    wr_en  = 1'b1;
                    wr_idx = top_idx;
                end else begin
                    wr_en   = 1'b1;
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                if (tos) begin
                    if (!empty) begin
                        rd_en = 1'b1;
                    end else begin
                        dout_zero = 1'b1;
                        unf_set   = 1'b1;
                    end
                end
            end
        endcase
    end

    // Storage array; intentionally not reset, contents are valid once written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= din;
        end
    end

    // Pointer, registered read port and sticky error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            ovf        <= 1'b0;
            unf        <= 1'b0;
        end else begin
            dout_valid <= rd_en;
            if (rd_en) begin
                dout <= mem[top_idx];
            end else if (dout_zero) begin
                dout <= '0;
            end
            if (cnt_inc) begin
                count <= count + CW'(1);
            end else if (cnt_dec) begin
                count <= count - CW'(1);
            end
            // A new error in the same cycle as clr_err keeps the flag set.
            ovf <= ovf_set | (ovf & ~clr_err);
            unf <= unf_set | (unf & ~clr_err);
        end
    end

endmodule

// File: tb/tb_stack_unit.sv
// Bench for stack_unit: directed scenarios plus a random stretch, checked
// against a queue-based reference stack and a scoreboard of read data.
module tb_stack_unit;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic             tos = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             clr_err = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             ovf;
    logic             unf;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model
    logic [WIDTH-1:0] m_stack[$];
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] m_dout = '0;
    logic             m_valid = 1'b0;
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;

    stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .tos        (tos),
        .din        (din),
        .clr_err    (clr_err),
        .dout       (dout),
        .dout_valid (dout_valid),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .ovf        (ovf),
        .unf        (unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_stack.delete();
        exp_q.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    // Drive one command for one clock, update the model, then compare.
    task automatic cmd(input logic p, input logic q, input logic t,
                       input logic [WIDTH-1:0] d, input logic c);
        logic ovf_s;
        logic unf_s;
        logic [WIDTH-1:0] got;
        push = p; pop = q; tos = t; din = d; clr_err = c;
        ovf_s   = 1'b0;
        unf_s   = 1'b0;
        m_valid = 1'b0;
        case ({p, q})
            2'b10: begin
                if (m_stack.size() < DEPTH) m_stack.push_back(d);
                else ovf_s = 1'b1;
            end
            2'b01: begin
                if (m_stack.size() > 0) begin
                    m_dout = m_stack.pop_back();
                    m_valid = 1'b1;
                end else begin
                    m_dout = '0;
                    unf_s = 1'b1;
                end
            end
            2'b11: begin
                if (m_stack.size() > 0) begin
                    m_dout = m_stack.pop_back();
                    m_stack.push_back(d);
                    m_valid = 1'b1;
                end else begin
                    m_stack.push_back(d);
                end
            end
            default: begin
                if (t) begin
                    if (m_stack.size() > 0) begin
                        m_dout = m_stack[m_stack.size()-1];
                        m_valid = 1'b1;
                    end else begin
                        m_dout = '0;
                        unf_s = 1'b1;
                    end
                end
            end
        endcase
        m_ovf = ovf_s | (m_ovf & ~c);
        m_unf = unf_s | (m_unf & ~c);
        if (m_valid) exp_q.push_back(m_dout);

        @(posedge clk);
        #1;
        chk("dout_valid", 32'(dout_valid), 32'(m_valid));
        if (dout_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected", 32'(dout_valid), 32'(0));
            end else begin
                got = exp_q.pop_front();
                chk("sb_dout", 32'(dout), 32'(got));
            end
        end
        chk("dout", 32'(dout), 32'(m_dout));
        chk("count", 32'(count), 32'(m_stack.size()));
        chk("full", 32'(full), 32'(m_stack.size() == DEPTH));
        chk("empty", 32'(empty), 32'(m_stack.size() == 0));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("unf", 32'(unf), 32'(m_unf));
        push = 1'b0; pop = 1'b0; tos = 1'b0; clr_err = 1'b0;
    endtask

    initial begin
        // power-on reset
        #12;
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_dout", 32'(dout), 32'(0));
        chk("rst_valid", 32'(dout_valid), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        // mid-run async reset discards entries without a clock edge
        cmd(1, 0, 0, 8'hC1, 0);
        cmd(1, 0, 0, 8'hC2, 0);
        cmd(1, 0, 0, 8'hC3, 0);
        chk("pre_rst_count", 32'(count), 32'(3));
        #2 rst = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'(0));
        chk("arst_empty", 32'(empty), 32'(1));
        chk("arst_dout", 32'(dout), 32'(0));
        chk("arst_ovf", 32'(ovf), 32'(0));
        chk("arst_unf", 32'(unf), 32'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cmd(0, 0, 0, 8'h00, 0);

        // LIFO order
        cmd(1, 0, 0, 8'h11, 0);
        cmd(1, 0, 0, 8'h22, 0);
        cmd(1, 0, 0, 8'h33, 0);
        cmd(0, 1, 0, 8'h00, 0);
        chk("lifo_1", 32'(dout), 32'h33);
        cmd(0, 1, 0, 8'h00, 0);
        chk("lifo_2", 32'(dout), 32'h22);
        cmd(0, 1, 0, 8'h00, 0);
        chk("lifo_3", 32'(dout), 32'h11);
        chk("lifo_empty", 32'(empty), 32'(1));

        // tos peek
        cmd(1, 0, 0, 8'hA5, 0);
        cmd(0, 0, 1, 8'h00, 0);
        chk("tos_dout", 32'(dout), 32'hA5);
        chk("tos_valid", 32'(dout_valid), 32'(1));
        chk("tos_count", 32'(count), 32'(1));
        cmd(0, 0, 0, 8'h00, 0);
        chk("idle_valid_drop", 32'(dout_valid), 32'(0));
        chk("idle_dout_hold", 32'(dout), 32'hA5);
        cmd(0, 1, 0, 8'h00, 0);
        chk("tos_pop", 32'(dout), 32'hA5);
        chk("tos_pop_count", 32'(count), 32'(0));

        // overflow
        for (int i = 1; i <= DEPTH; i++) cmd(1, 0, 0, WIDTH'(i), 0);
        cmd(1, 0, 0, 8'hFF, 0);
        chk("ovf_full", 32'(full), 32'(1));
        chk("ovf_count", 32'(count), 32'(DEPTH));
        chk("ovf_flag", 32'(ovf), 32'(1));
        cmd(0, 1, 0, 8'h00, 0);
        chk("ovf_pop", 32'(dout), 32'h08);
        cmd(0, 0, 0, 8'h00, 1);
        chk("ovf_clr", 32'(ovf), 32'(0));
        for (int i = 0; i < DEPTH - 1; i++) cmd(0, 1, 0, 8'h00, 0);

        // underflow and clear
        cmd(0, 1, 0, 8'h00, 0);
        chk("unf_flag", 32'(unf), 32'(1));
        chk("unf_dout", 32'(dout), 32'(0));
        chk("unf_valid", 32'(dout_valid), 32'(0));
        cmd(0, 0, 0, 8'h00, 1);
        chk("unf_clr", 32'(unf), 32'(0));
        cmd(0, 0, 1, 8'h00, 1);
        chk("unf_clr_vs_set", 32'(unf), 32'(1));
        cmd(0, 0, 0, 8'h00, 1);

        // simultaneous push+pop
        cmd(1, 0, 0, 8'h10, 0);
        cmd(1, 0, 0, 8'h20, 0);
        cmd(1, 1, 0, 8'h99, 0);
        chk("rep_dout", 32'(dout), 32'h20);
        chk("rep_count", 32'(count), 32'(2));
        cmd(0, 1, 0, 8'h00, 0);
        chk("rep_pop", 32'(dout), 32'h99);
        cmd(0, 1, 0, 8'h00, 0);
        cmd(1, 1, 0, 8'h44, 0);
        chk("rep_empty_count", 32'(count), 32'(1));
        chk("rep_empty_unf", 32'(unf), 32'(0));
        chk("rep_empty_valid", 32'(dout_valid), 32'(0));
        cmd(0, 1, 0, 8'h00, 0);
        chk("rep_empty_pop", 32'(dout), 32'h44);

        // random stretch, biased towards push so the stack fills and drains
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 9);
            cmd(r < 4 || r == 8, (r >= 4 && r < 7) || r == 8, r == 7,
                WIDTH'($urandom), $urandom_range(0, 7) == 0);
        end

        chk("sb_drained", 32'(exp_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Operand stack that services the push/pop/tos commands issued by the stack-machine multicycle controller.
- Holds DEPTH words of WIDTH bits and presents the popped or peeked word on a registered output one cycle after the command.
- Sits between the controller/datapath (MtoS mux supplies din; dout feeds the A/B operand registers) and reports full/empty plus sticky overflow/underflow error flags.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 8, number of stack entries; must be a power of two, >= 2.
- CW (localparam), clog2(DEPTH+1), width of the count output.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- push  input  1  write din onto the stack this cycle.
- pop  input  1  remove the top entry and register it onto dout.
- tos  input  1  register the top entry onto dout without removing it.
- din  input  WIDTH  data to push.
- clr_err  input  1  synchronous clear of ovf and unf.
- dout  output  WIDTH  registered read data.
- dout_valid  output  1  one-cycle pulse: dout was updated by a successful pop or tos.
- count  output  CW  number of valid entries, 0..DEPTH.
- full  output  1  combinational, count==DEPTH.
- empty  output  1  combinational, count==0.
- ovf  output  1  sticky: push attempted while full.
- unf  output  1  sticky: pop or tos attempted while empty.

Behaviour:
- Reset (rst=0, async): count=0, dout=0, dout_valid=0, ovf=0, unf=0. Storage array is not reset; contents are don't-care until written. Reset mid-operation discards all entries immediately.
- Storage: mem[0..DEPTH-1]. Top entry is mem[count-1]. All updates occur on the rising clk edge.
- dout_valid defaults to 0 every cycle unless set by one of the rules below.
- Command decode uses priority on {push, pop}, evaluated each cycle:
  - push only, not full: mem[count]<=din; count+1. dout is unchanged.
  - push only, full: no write, count unchanged; ovf<=1.
  - pop only, not empty: dout<=mem[count-1]; count-1; dout_valid<=1.
  - pop only, empty: count unchanged; dout<=0; unf<=1; dout_valid stays 0.
  - push and pop together, not empty: dout<=mem[count-1]; mem[count-1]<=din; count unchanged; dout_valid<=1 (replace-top).
  - push and pop together, empty: behaves as push only. No unf; dout unchanged.
- tos: acts only when push=0 and pop=0; ignored otherwise.
  - Not empty: dout<=mem[count-1]; dout_valid<=1; count unchanged.
  - Empty: dout<=0; unf<=1.
- Latency: dout and dout_valid are valid in the cycle after the command, so the controller loads A/B one state later.
- Pop data is the value read before the pointer decrements; no read-during-write hazard within a single command.
- clr_err=1 clears ovf and unf at the edge. A new error in the same cycle wins, so the flag is set.
- No wrap-around: count saturates at 0 and at DEPTH; the pointer never wraps.
- Idle (all commands 0): every register holds its value.

Test Plan:
- Reset then idle: drive rst=0 mid-run after 3 pushes, release -> count=0, empty=1, dout=0, ovf=unf=0 immediately, without waiting for a clk edge.
- LIFO order: push 8'h11, 8'h22, 8'h33, then pop x3 -> dout 8'h33, 8'h22, 8'h11 on successive cycles, each following a dout_valid pulse; count goes 3->0, empty=1.
- tos peek: push 8'hA5, tos -> next cycle dout=8'hA5, dout_valid=1, count stays 1; a following pop returns 8'hA5 and leaves count=0.
- Overflow (DEPTH=8): push 8'h01..8'h08, then push 8'hFF -> full=1, count=8, ovf=1; pop returns 8'h08, not 8'hFF.
- Underflow and clear: pop on empty -> unf=1, dout=0, dout_valid=0. Next, clr_err=1 -> unf=0. Then clr_err=1 together with tos on empty -> unf stays 1.
- Simultaneous: stack holds 8'h10, 8'h20; push=pop=1 with din=8'h99 -> dout=8'h20, count=2; then pop -> 8'h99. On an empty stack, push=pop=1 with din=8'h44 -> count=1, unf=0.
